// File: rtl/sram_like_pkg.sv
// Shared encodings and helper types for the sram-like bus arbiter.
package sram_like_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Request fields that travel with bus_req toward the bridge.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants won while an instruction request was waiting.
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs,
  input  logic       grant_inst,
  input  logic       inst_pending,
  output logic       starved,
  output logic [3:0] cnt
);

  localparam logic [3:0] LIMIT_V = 4'(LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (hs) begin
      if (grant_inst) begin
        cnt <= '0;
      end else if (inst_pending && (cnt != LIMIT_V)) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign starved = (cnt == LIMIT_V);

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master, one-slave sram-like arbiter: data has priority, a starvation
// counter forces an instruction grant after STARVE_LIMIT consecutive data wins.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // bridge side
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  // debug visibility
  output logic        dbg_state,
  output logic [3:0]  dbg_starve_cnt
);

  // Handshake contract: a master holds req and its fields stable until it
  // sees addr_ok; addr_ok/data_ok are single-cycle pulses passed straight
  // through from the bridge to whichever master owns the transfer.

  state_e      state;
  owner_e      owner;
  logic        idle;
  logic        starved;
  logic        grant_inst;
  logic        grant_data;
  logic        sel_inst;
  logic        hs;
  logic        done_idle;
  logic        done_busy;
  req_fields_t inst_f;
  req_fields_t data_f;
  req_fields_t bus_f;

  assign inst_f = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_f = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  always_comb begin
    idle       = (state == IDLE);
    grant_inst = inst_req & (~data_req | starved);
    grant_data = data_req & ~grant_inst;
    // While busy the bus fields follow the owner so the bridge sees a stable view.
    sel_inst   = idle ? grant_inst : (owner == OWN_INST);
    bus_f      = sel_inst ? inst_f : data_f;
    bus_req    = rst & idle & (inst_req | data_req);
    hs         = bus_req & bus_addr_ok;
    done_idle  = hs & bus_data_ok;
    done_busy  = rst & ~idle & bus_data_ok;
  end

  assign bus_wr    = bus_f.wr;
  assign bus_size  = bus_f.size;
  assign bus_addr  = bus_f.addr;
  assign bus_wdata = bus_f.wdata;

  assign inst_addr_ok = hs & grant_inst;
  assign data_addr_ok = hs & grant_data;
  assign inst_data_ok = (done_idle & grant_inst) | (done_busy & (owner == OWN_INST));
  assign data_data_ok = (done_idle & grant_data) | (done_busy & (owner == OWN_DATA));

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_INST;
    end else begin
      case (state)
        IDLE: begin
          // A same-cycle data_ok completes the transfer without a BUSY phase.
          if (hs && !bus_data_ok) begin
            state <= BUSY;
            owner <= grant_inst ? OWN_INST : OWN_DATA;
          end
        end
        BUSY: begin
          if (bus_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk          (clk),
    .rst          (rst),
    .hs           (hs),
    .grant_inst   (grant_inst),
    .inst_pending (inst_req),
    .starved      (starved),
    .cnt          (dbg_starve_cnt)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and randomized bench for sram_like_arbiter against a transaction-level model.
module tb_sram_like_arbiter;
  import sram_like_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        dbg_state;
  logic [3:0]  dbg_starve_cnt;

  sram_like_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the owner of the outstanding transfer (0 = inst, 1 = data).
  logic [0:0] exp_q[$];
  int m_wins = 0;
  bit inst_acc = 0, data_acc = 0;
  bit check_en = 1;

  // 0 = nobody requesting, 1 = inst wins, 2 = data wins
  function automatic int winner();
    if (inst_req && data_req) return (m_wins >= LIMIT) ? 1 : 2;
    if (data_req) return 2;
    if (inst_req) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wins = 0;
      exp_q.delete();
      inst_acc = 0;
      data_acc = 0;
    end else begin
      int w;
      w = winner();
      inst_acc = 0;
      data_acc = 0;
      if (exp_q.size() == 0) begin
        if (w != 0 && bus_addr_ok) begin
          inst_acc = (w == 1);
          data_acc = (w == 2);
          if (w == 1) m_wins = 0;
          else if (inst_req) m_wins = (m_wins + 1 > LIMIT) ? LIMIT : m_wins + 1;
          if (!bus_data_ok) exp_q.push_back((w == 2) ? 1'b1 : 1'b0);
        end
      end else if (bus_data_ok) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_outputs();
    int w;
    bit idle;
    logic [66:0] fi, fd, bf;
    fi = {inst_wr, inst_size, inst_addr, inst_wdata};
    fd = {data_wr, data_size, data_addr, data_wdata};
    bf = {bus_wr, bus_size, bus_addr, bus_wdata};
    chk("inst_rdata", inst_rdata, bus_rdata);
    chk("data_rdata", data_rdata, bus_rdata);
    if (!rst) begin
      chk("rst_bus_req", bus_req, 0);
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    end else begin
      idle = (exp_q.size() == 0);
      w = winner();
      chk("bus_req", bus_req, idle && w != 0);
      chk("inst_addr_ok", inst_addr_ok, idle && w == 1 && bus_addr_ok);
      chk("data_addr_ok", data_addr_ok, idle && w == 2 && bus_addr_ok);
      if (idle) begin
        chk("inst_data_ok", inst_data_ok, w == 1 && bus_addr_ok && bus_data_ok);
        chk("data_data_ok", data_data_ok, w == 2 && bus_addr_ok && bus_data_ok);
        if (w != 0) chk("bus_fields", bf, (w == 1) ? fi : fd);
      end else begin
        chk("inst_data_ok", inst_data_ok, exp_q[0] == 1'b0 && bus_data_ok);
        chk("data_data_ok", data_data_ok, exp_q[0] == 1'b1 && bus_data_ok);
        chk("bus_fields", bf, (exp_q[0] == 1'b0) ? fi : fd);
      end
      chk("state", dbg_state, !idle);
      chk("starve_cnt", dbg_starve_cnt, m_wins);
    end
  endtask

  // single compare process, sampling mid-cycle after inputs have settled
  always @(negedge clk) begin
    #2;
    if (check_en) check_outputs();
  end

  // ---------------- driver helpers ----------------
  task automatic quiet();
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("reset_state", dbg_state, 0);
    chk("reset_cnt", dbg_starve_cnt, 0);

    // single instruction read
    @(negedge clk);
    inst_req = 1; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = 32'hBFC0_0000;
    #1;
    chk("t1_bus_req", bus_req, 1);
    chk("t1_bus_addr", bus_addr, 32'hBFC0_0000);
    @(negedge clk);
    bus_addr_ok = 1;
    #1;
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0;
    #1;
    chk("t1_busy", dbg_state, 1);
    chk("t1_no_req_busy", bus_req, 0);
    @(negedge clk);
    bus_data_ok = 1; bus_rdata = 32'h3C1D_0001;
    #1;
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C1D_0001);
    chk("t1_data_data_ok", data_data_ok, 0);
    @(negedge clk);
    quiet();
    #1;
    chk("t1_idle", dbg_state, 0);

    // simultaneous requests: data first, inst after data completes
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_wr = 0; data_size = SIZE_WORD; data_addr = 32'h0000_2000;
    bus_addr_ok = 1;
    #1;
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok", inst_addr_ok, 0);
    chk("t2_bus_addr", bus_addr, 32'h0000_2000);
    @(negedge clk);
    data_req = 0;
    #1;
    chk("t2_inst_wait", inst_addr_ok, 0);
    @(negedge clk);
    bus_addr_ok = 0; bus_data_ok = 1;
    #1;
    chk("t2_data_data_ok", data_data_ok, 1);
    chk("t2_inst_still_wait", inst_addr_ok, 0);
    @(negedge clk);
    bus_data_ok = 0; bus_addr_ok = 1;
    #1;
    chk("t2_inst_addr_ok", inst_addr_ok, 1);
    chk("t2_bus_addr_inst", bus_addr, 32'h0000_1000);
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1;
    chk("t2_inst_data_ok", inst_data_ok, 1);
    @(negedge clk);
    quiet();

    // starvation: four data grants, then inst
    @(negedge clk);
    inst_req = 1; data_req = 1;
    for (int k = 0; k < LIMIT; k++) begin
      bus_addr_ok = 1; bus_data_ok = 0;
      #1;
      chk("t3_data_grant", data_addr_ok, 1);
      @(negedge clk);
      bus_addr_ok = 0; bus_data_ok = 1;
      #1;
      chk("t3_data_done", data_data_ok, 1);
      @(negedge clk);
    end
    bus_addr_ok = 1; bus_data_ok = 0;
    #1;
    chk("t3_cnt_sat", dbg_starve_cnt, 4);
    chk("t3_inst_grant", inst_addr_ok, 1);
    chk("t3_data_blocked", data_addr_ok, 0);
    @(negedge clk);
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1;
    chk("t3_cnt_clear", dbg_starve_cnt, 0);
    chk("t3_inst_done", inst_data_ok, 1);
    @(negedge clk);
    quiet();

    // same-cycle completion with a queued inst request
    @(negedge clk);
    data_req = 1; data_wr = 1; data_wdata = 32'hCAFE_F00D; inst_req = 1;
    bus_addr_ok = 1; bus_data_ok = 1;
    #1;
    chk("t4_data_addr_ok", data_addr_ok, 1);
    chk("t4_data_data_ok", data_data_ok, 1);
    chk("t4_bus_wr", bus_wr, 1);
    @(negedge clk);
    data_req = 0; bus_data_ok = 0; bus_addr_ok = 1;
    #1;
    chk("t4_still_idle", dbg_state, 0);
    chk("t4_inst_granted", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    @(negedge clk);
    quiet();

    // spurious data_ok, then reset while busy
    @(negedge clk);
    bus_data_ok = 1;
    #1;
    chk("t5_spurious", {inst_data_ok, data_data_ok}, 0);
    @(negedge clk);
    bus_data_ok = 0; data_req = 1; data_wr = 0; bus_addr_ok = 1;
    @(negedge clk);
    data_req = 0; bus_addr_ok = 0; inst_req = 1; bus_data_ok = 1;
    #1;
    rst = 0;
    #1;
    chk("t5_rst_bus_req", bus_req, 0);
    chk("t5_rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("t5_rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    @(negedge clk);
    rst = 1; bus_data_ok = 0; bus_addr_ok = 1;
    #1;
    chk("t5_after_rst_state", dbg_state, 0);
    chk("t5_after_rst_grant", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    @(negedge clk);
    quiet();

    // randomized traffic; masters hold a request until it is accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!inst_req || inst_acc) begin
        inst_req   = ($urandom_range(0, 2) != 0);
        inst_wr    = 1'($urandom_range(0, 1));
        inst_size  = 2'($urandom_range(0, 2));
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      if (!data_req || data_acc) begin
        data_req   = ($urandom_range(0, 4) != 0);
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      bus_addr_ok = 1'($urandom_range(0, 1));
      bus_data_ok = ($urandom_range(0, 3) == 0);
      bus_rdata   = $urandom;
      rst         = ($urandom_range(0, 299) != 0);
    end

    @(negedge clk);
    rst = 1;
    quiet();
    repeat (3) @(negedge clk);
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master, one-slave arbiter for the CPU's sram-like bus. It takes the instruction-side request stream (from the instruction sram-to-sram-like adapter) and the data-side request stream (from the data adapter) and shares one sram-like port toward the AXI bridge. At most one transaction is outstanding at a time. Data requests have priority, and a starvation counter guarantees instruction fetch progress.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants won while inst_req was pending, after which the next grant goes to inst; range 1..15.

Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- inst_req, inst_wr  in  1  instruction master request / write flag
- inst_size  in  2  transfer size
- inst_addr, inst_wdata  in  32  address / write data
- inst_addr_ok, inst_data_ok  out  1  handshakes returned to the instruction master
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data master request, same meaning as the inst_* inputs
- data_addr_ok, data_data_ok  out  1  handshakes returned to the data master
- data_rdata  out  32  read data
- bus_req, bus_wr, bus_size, bus_addr, bus_wdata  out  1/1/2/32/32  toward the bridge
- bus_addr_ok, bus_data_ok  in  1  bridge handshakes
- bus_rdata  in  32  bridge read data

## Operation
States:
- IDLE: no transaction outstanding.
- BUSY: a transaction is outstanding. Register `owner` (INST/DATA) records which master it belongs to.

In IDLE, grant selection (combinational):
- data_req only → DATA.
- inst_req only → INST.
- Both → DATA, unless starve_cnt == STARVE_LIMIT, then INST.

Bus drive:
- In IDLE, bus_req = req of the granted master; bus_wr/size/addr/wdata are muxed from the granted master.
- In BUSY, bus_req = 0 and the bus_* fields hold the muxed values of `owner`.

addr_ok routing:
- IDLE: <granted>_addr_ok = bus_addr_ok; the other master's addr_ok = 0.
- BUSY: both addr_ok = 0.

Address handshake (IDLE, bus_req & bus_addr_ok):
- bus_data_ok = 0 → go to BUSY; owner ← granted master.
- bus_data_ok = 1 in the same cycle → stay in IDLE; the data_ok is forwarded to the granted master that cycle.

BUSY completion:
- bus_data_ok → <owner>_data_ok = 1, then return to IDLE.

Read data:
- inst_rdata = data_rdata = bus_rdata, broadcast at all times; a master samples it only on its own data_ok.

Starvation counter (4 bits):
- Updated on each completed address handshake.
- DATA granted while inst_req was high → increment, saturating at STARVE_LIMIT.
- INST granted → clear to 0.
- No inst_req pending at the DATA grant → unchanged.

Error handling:
- bus_data_ok in IDLE with no handshake that cycle is spurious: ignore it and drive no data_ok.

Reset (rst = 0, asynchronous):
- state ← IDLE, owner ← INST, starve_cnt ← 0.
- While reset is asserted, bus_req, both addr_ok and both data_ok are forced to 0.
- Reset mid-transaction drops the outstanding transfer; the bridge is reset by the same rst.

## Timing
- Zero-cycle combinational paths: *_req → bus_req; bus_addr_ok → *_addr_ok; bus_data_ok → *_data_ok. The arbiter adds no latency.
- The next request can be issued in the cycle after data_ok (one IDLE cycle minimum between transactions that each need a BUSY phase).
- Grant is stable within a cycle. If a master drops its req before addr_ok, nothing is recorded; arbitration is re-evaluated the next cycle.
- A master must hold req and its fields stable until its addr_ok (sram-like rule). The arbiter relies on this and does not latch the request fields.

## Structure
Shared package sram_like_pkg holds:
- state encoding: IDLE = 1'b0, BUSY = 1'b1
- owner encoding: OWN_INST = 1'b0, OWN_DATA = 1'b1
- SIZE_WORD = 2'b10

Sub-module arb_starve_ctr holds the saturating 4-bit counter.
- Inputs: hs, grant_inst, inst_pending.
- Parameter: LIMIT.
- Output: starved.
- All remaining logic (FSM, muxes, routing) lives in the top module.

## Test plan
- **Single inst read.** inst_req, addr 0xBFC00000; bus_addr_ok at cycle 1, bus_data_ok with rdata 0x3C1D0001 at cycle 3. Required: inst_addr_ok in cycle 1, inst_data_ok in cycle 3, inst_rdata = 0x3C1D0001, data_* handshakes stay 0.
- **Simultaneous requests.** inst and data both request, starve_cnt = 0. Required: data is granted first, with bus_addr = data_addr. inst_addr_ok appears only in the IDLE cycle after data's data_ok.
- **Starvation.** data_req held high and inst_req held high, STARVE_LIMIT = 4. Required: four data transactions complete, then the fifth grant goes to inst; the counter returns to 0 after it.
- **Same-cycle completion.** bus_addr_ok and bus_data_ok both asserted for a data write. Required: data_addr_ok and data_data_ok both asserted in that cycle, state stays IDLE, and a queued inst_req is granted the next cycle.
- **Spurious data_ok and mid-transaction reset.** bus_data_ok asserted in IDLE → no *_data_ok. Then rst = 0 while in BUSY → bus_req, all *_addr_ok and all *_data_ok are 0 immediately. After release, a new inst_req is granted normally.
